// File: rtl/ninjin_renkon_mem_arb_if.sv
// Host and core-read signal bundle for the renkon weight/feature buffer arbiter.
// Latency: none (wiring only).
// Backpressure: core_rvalid/core_rready handshake; the host side is never stalled.
interface ninjin_renkon_mem_arb_if #(
    parameter int DATA_WIDTH  = 32,
    parameter int WADDR_WIDTH = 10,
    parameter int LEN_WIDTH   = 8
);
    logic                   host_en;
    logic                   host_we;
    logic [WADDR_WIDTH-1:0] host_addr;
    logic [DATA_WIDTH-1:0]  host_wdata;
    logic [DATA_WIDTH-1:0]  host_rdata;
    logic                   core_start;
    logic [WADDR_WIDTH-1:0] core_base;
    logic [LEN_WIDTH-1:0]   core_len;
    logic                   core_rvalid;
    logic                   core_rready;
    logic [DATA_WIDTH-1:0]  core_rdata;
    logic                   core_rlast;
    logic                   core_busy;
    logic                   core_done;

    // Requester side: AXI slave front-end plus the renkon core consumer.
    modport master (
        output host_en, host_we, host_addr, host_wdata,
        input  host_rdata,
        output core_start, core_base, core_len, core_rready,
        input  core_rvalid, core_rdata, core_rlast, core_busy, core_done
    );

    // Arbiter side.
    modport slave (
        input  host_en, host_we, host_addr, host_wdata,
        output host_rdata,
        input  core_start, core_base, core_len, core_rready,
        output core_rvalid, core_rdata, core_rlast, core_busy, core_done
    );
endinterface

// File: rtl/ninjin_renkon_mem_arb.sv
// Single-port RAM shared by host (priority) and a burst-read core engine feeding a small FIFO.
// Latency: host read 1 cycle; core start -> first rvalid 2 cycles, then 1 word/cycle.
// Backpressure: core reads issue only while FIFO+inflight has room and host is idle. Optional
// stall counter enabled with NINJIN_MEM_ARB_STAT_EN.
module ninjin_renkon_mem_arb #(
    parameter int DATA_WIDTH  = 32,
    parameter int WADDR_WIDTH = 10,
    parameter int LEN_WIDTH   = 8,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  xrst,
    ninjin_renkon_mem_arb_if.slave bus
`ifdef NINJIN_MEM_ARB_STAT_EN
    ,
    output logic [15:0]           stall_cnt
`endif
);
    localparam int RAM_DEPTH = 1 << WADDR_WIDTH;
    localparam int PW        = $clog2(FIFO_DEPTH);
    localparam int CW        = PW + 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                 state;
    logic [WADDR_WIDTH-1:0] addr_cnt;
    logic [LEN_WIDTH-1:0]   rem_cnt;
    logic                   inflight;
    logic                   inflight_last;
    logic                   busy_q;
    logic                   done_q;

    logic [DATA_WIDTH-1:0]  ram [0:RAM_DEPTH-1];
    logic [DATA_WIDTH-1:0]  rd_q;
    logic [WADDR_WIDTH-1:0] ram_addr;

    logic [DATA_WIDTH-1:0]  fifo_dat [0:FIFO_DEPTH-1];
    logic                   fifo_lst [0:FIFO_DEPTH-1];
    logic [PW-1:0]          wr_ptr;
    logic [PW-1:0]          rd_ptr;
    logic [CW-1:0]          fifo_count;

    logic [CW-1:0]          occ;
    logic                   room;
    logic                   issue;
    logic                   final_issue;
    logic                   fifo_empty;
    logic                   head_vld;
    logic [DATA_WIDTH-1:0]  head_dat;
    logic                   head_lst;
    logic                   hs;
    logic                   push;
    logic                   pop;
    logic                   start_acc;

    // Space accounting counts the word already read from RAM but not yet in the FIFO.
    assign occ         = fifo_count + CW'(inflight);
    assign room        = occ < CW'(FIFO_DEPTH);
    assign issue       = (state == RUN) && !bus.host_en && room;
    assign final_issue = issue && (rem_cnt == '0);
    assign start_acc   = (state == IDLE) && bus.core_start;

    // Head of the output stream: FIFO entry, or the RAM output directly when the FIFO is empty.
    assign fifo_empty = (fifo_count == '0);
    assign head_vld   = !fifo_empty || inflight;
    assign head_dat   = fifo_empty ? rd_q : fifo_dat[rd_ptr];
    assign head_lst   = fifo_empty ? inflight_last : fifo_lst[rd_ptr];
    assign hs         = head_vld && bus.core_rready;
    assign pop        = hs && !fifo_empty;
    assign push       = inflight && !(fifo_empty && bus.core_rready);

    // RAM address mux: host always wins, otherwise the core counter when it issues.
    always_comb begin
        ram_addr = bus.host_addr;
        if (!bus.host_en && issue) begin
            ram_addr = addr_cnt;
        end
    end

    // RAM array write port; contents intentionally survive reset.
    always_ff @(posedge clk) begin
        if (bus.host_en && bus.host_we) begin
            ram[bus.host_addr] <= bus.host_wdata;
        end
    end

    // Registered RAM read, shared by host reads and core issues.
    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            rd_q <= '0;
        end else begin
            rd_q <= ram[ram_addr];
        end
    end

    // Burst FSM: address/remaining counters, in-flight tag and registered status outputs.
    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            state         <= IDLE;
            addr_cnt      <= '0;
            rem_cnt       <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            inflight      <= issue;
            inflight_last <= final_issue;
            done_q        <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.core_start) begin
                        state    <= RUN;
                        addr_cnt <= bus.core_base;
                        rem_cnt  <= bus.core_len;
                        busy_q   <= 1'b1;
                    end
                end
                RUN: begin
                    if (issue) begin
                        addr_cnt <= addr_cnt + WADDR_WIDTH'(1);
                        rem_cnt  <= rem_cnt - LEN_WIDTH'(1);
                        if (final_issue) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // The rlast handshake consumes the final word; done shows in the next cycle
                    // while still busy, so it cannot overlap a new start acceptance.
                    if (hs && head_lst) begin
                        done_q <= 1'b1;
                    end
                    if (fifo_empty && !inflight) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    // FIFO pointers and occupancy; push and pop may coincide at any level.
    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            fifo_count <= fifo_count + CW'(push) - CW'(pop);
        end
    end

    // FIFO storage; validity comes from the pointers so no reset is needed.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_dat[wr_ptr] <= rd_q;
            fifo_lst[wr_ptr] <= inflight_last;
        end
    end

    assign bus.host_rdata  = rd_q;
    assign bus.core_rvalid = head_vld;
    assign bus.core_rdata  = head_vld ? head_dat : '0;
    assign bus.core_rlast  = head_vld && head_lst;
    assign bus.core_busy   = busy_q;
    assign bus.core_done   = done_q;

`ifdef NINJIN_MEM_ARB_STAT_EN
    // Cycles in which only the host blocked a core read that had FIFO room.
    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            stall_cnt <= '0;
        end else if (start_acc) begin
            stall_cnt <= '0;
        end else if ((state == RUN) && bus.host_en && room && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif
endmodule
